// File: rtl/cpu19_pkg.sv
// cpu19_pkg: shared widths, call/return FSM states and fault codes
package cpu19_pkg;
    localparam int ADDR_W = 19;
    localparam int DEPTH  = 15;
    typedef enum logic [2:0] {IDLE, CALL_PUSH, RET_POP, RESP, FAULT} crc_state_t;
    localparam logic [1:0] FLT_NONE = 2'd0;
    localparam logic [1:0] FLT_OVF  = 2'd1;
    localparam logic [1:0] FLT_UNF  = 2'd2;
    localparam logic [1:0] FLT_ILL  = 2'd3;
endpackage

// File: rtl/call_return_ctrl_if.sv
// call_return_ctrl_if: decode-side request/response and return-stack signals
interface call_return_ctrl_if;
    import cpu19_pkg::*;
    logic              call_req;
    logic              ret_req;
    logic [ADDR_W-1:0] cur_pc;
    logic [ADDR_W-1:0] call_target;
    logic              fault_clear;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] next_pc;
    logic              fault;
    logic [1:0]        fault_code;
    logic [3:0]        call_depth;
    logic              stk_push;
    logic              stk_pop;
    logic [ADDR_W-1:0] stk_push_data;
    logic [ADDR_W-1:0] stk_pop_data;
    logic              stk_empty;
    logic              stk_full;
    modport master (
        output call_req, ret_req, cur_pc, call_target, fault_clear, stk_pop_data, stk_empty, stk_full,
        input  busy, done, next_pc, fault, fault_code, call_depth, stk_push, stk_pop, stk_push_data
    );
    modport slave (
        input  call_req, ret_req, cur_pc, call_target, fault_clear, stk_pop_data, stk_empty, stk_full,
        output busy, done, next_pc, fault, fault_code, call_depth, stk_push, stk_pop, stk_push_data
    );
endinterface

// File: rtl/call_return_ctrl.sv
// call_return_ctrl: CALL/RET sequencer for the return-address stack with sticky fault reporting
module call_return_ctrl
    import cpu19_pkg::*;
(
    input logic clk,
    input logic reset,
    call_return_ctrl_if.slave bus
);
    crc_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ret_addr_q, ret_addr_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic [ADDR_W-1:0] next_pc_q, next_pc_d;
    logic [1:0]        fault_code_q, fault_code_d;
    logic [3:0]        depth_q, depth_d;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ret_addr_q   <= '0;
            tgt_q        <= '0;
            next_pc_q    <= '0;
            fault_code_q <= FLT_NONE;
            depth_q      <= '0;
        end else begin
            state_q      <= state_d;
            ret_addr_q   <= ret_addr_d;
            tgt_q        <= tgt_d;
            next_pc_q    <= next_pc_d;
            fault_code_q <= fault_code_d;
            depth_q      <= depth_d;
        end
    end
    always_comb begin
        state_d      = state_q;
        ret_addr_d   = ret_addr_q;
        tgt_d        = tgt_q;
        next_pc_d    = next_pc_q;
        fault_code_d = fault_code_q;
        depth_d      = depth_q;
        case (state_q)
            IDLE: begin
                // illegal dual request outranks the full/empty checks
                if (bus.call_req && bus.ret_req) begin
                    state_d      = FAULT;
                    fault_code_d = FLT_ILL;
                end else if (bus.call_req) begin
                    state_d      = bus.stk_full ? FAULT : CALL_PUSH;
                    fault_code_d = bus.stk_full ? FLT_OVF : fault_code_q;
                    ret_addr_d   = bus.cur_pc + 1'b1;
                    tgt_d        = bus.call_target;
                end else if (bus.ret_req) begin
                    state_d      = bus.stk_empty ? FAULT : RET_POP;
                    fault_code_d = bus.stk_empty ? FLT_UNF : fault_code_q;
                end
            end
            CALL_PUSH: begin
                next_pc_d = tgt_q;
                depth_d   = depth_q + 4'd1;
                state_d   = RESP;
            end
            RET_POP: begin
                next_pc_d = bus.stk_pop_data;
                depth_d   = depth_q - 4'd1;
                state_d   = RESP;
            end
            RESP: state_d = IDLE;
            FAULT: begin
                state_d      = bus.fault_clear ? IDLE : FAULT;
                fault_code_d = bus.fault_clear ? FLT_NONE : fault_code_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        bus.busy          = state_q != IDLE;
        bus.done          = state_q == RESP;
        bus.fault         = state_q == FAULT;
        bus.fault_code    = fault_code_q;
        bus.next_pc       = next_pc_q;
        bus.call_depth    = depth_q;
        bus.stk_push      = state_q == CALL_PUSH;
        bus.stk_pop       = state_q == RET_POP;
        bus.stk_push_data = state_q == CALL_PUSH ? ret_addr_q : '0;
    end
endmodule

// File: tb/tb_call_return_ctrl.sv
// tb_call_return_ctrl: randomized CALL/RET traffic checked against a queue-based reference model
module tb_call_return_ctrl;
    import cpu19_pkg::*;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    call_return_ctrl_if bus();
    call_return_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
    logic [ADDR_W-1:0] mem [16];
    logic [3:0]        sp;
    always @(posedge clk) begin
        if (reset) sp <= 4'd15;
        else if (bus.stk_push) begin
            mem[sp] <= bus.stk_push_data;
            sp      <= sp - 4'd1;
        end else if (bus.stk_pop) sp <= sp + 4'd1;
    end
    assign bus.stk_empty    = sp == 4'd15;
    assign bus.stk_full     = sp == 4'd0;
    assign bus.stk_pop_data = sp == 4'd15 ? '0 : mem[sp + 4'd1];
    int vectors = 0;
    int miscompares = 0;
    logic [ADDR_W-1:0] ref_q [$];
    logic [ADDR_W-1:0] exp_pc = '0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check_idle(input string tag);
        chk({tag, " busy"}, bus.busy, 0);
        chk({tag, " done"}, bus.done, 0);
        chk({tag, " fault"}, bus.fault, 0);
        chk({tag, " code"}, bus.fault_code, 0);
        chk({tag, " strobes"}, {bus.stk_push, bus.stk_pop}, 0);
        chk({tag, " depth"}, bus.call_depth, ref_q.size());
        chk({tag, " next_pc"}, bus.next_pc, exp_pc);
        chk({tag, " empty"}, bus.stk_empty, ref_q.size() == 0);
    endtask
    task automatic expect_fault(input logic [1:0] code, input bit noise);
        chk("flt fault", bus.fault, 1);
        chk("flt busy", bus.busy, 1);
        chk("flt code", bus.fault_code, code);
        chk("flt strobes", {bus.stk_push, bus.stk_pop}, 0);
        repeat ($urandom_range(0, 2)) begin
            if (noise) {bus.call_req, bus.ret_req} = 2'($urandom);
            tick();
            chk("flt hold", bus.fault, 1);
            chk("flt hold code", bus.fault_code, code);
            chk("flt hold strobes", {bus.stk_push, bus.stk_pop}, 0);
        end
        bus.fault_clear = 1'b1;
        tick();
        {bus.call_req, bus.ret_req, bus.fault_clear} = 3'b000;
        check_idle("flt clr");
    endtask
    task automatic do_call(input logic [ADDR_W-1:0] pc, input logic [ADDR_W-1:0] tgt, input bit noise);
        logic [ADDR_W-1:0] ra;
        ra = ADDR_W'((int'(pc) + 1) % (1 << ADDR_W));
        bus.call_req = 1'b1;
        bus.cur_pc = pc;
        bus.call_target = tgt;
        tick();
        bus.call_req = 1'b0;
        if (ref_q.size() == DEPTH) expect_fault(FLT_OVF, noise);
        else begin
            ref_q.push_back(ra);
            exp_pc = tgt;
            if (noise) {bus.call_req, bus.ret_req} = 2'($urandom);
            chk("call busy", bus.busy, 1);
            chk("call push", bus.stk_push, 1);
            chk("call pop", bus.stk_pop, 0);
            chk("call data", bus.stk_push_data, ra);
            chk("call done early", bus.done, 0);
            tick();
            chk("call done", bus.done, 1);
            chk("call next_pc", bus.next_pc, exp_pc);
            chk("call depth", bus.call_depth, ref_q.size());
            chk("call push off", bus.stk_push, 0);
            {bus.call_req, bus.ret_req} = 2'b00;
            tick();
            check_idle("call end");
        end
    endtask
    task automatic do_ret(input bit noise);
        bus.ret_req = 1'b1;
        tick();
        bus.ret_req = 1'b0;
        if (ref_q.size() == 0) expect_fault(FLT_UNF, noise);
        else begin
            exp_pc = ref_q.pop_back();
            if (noise) {bus.call_req, bus.ret_req} = 2'($urandom);
            chk("ret busy", bus.busy, 1);
            chk("ret pop", bus.stk_pop, 1);
            chk("ret push", bus.stk_push, 0);
            tick();
            chk("ret done", bus.done, 1);
            chk("ret next_pc", bus.next_pc, exp_pc);
            chk("ret depth", bus.call_depth, ref_q.size());
            chk("ret pop off", bus.stk_pop, 0);
            {bus.call_req, bus.ret_req} = 2'b00;
            tick();
            check_idle("ret end");
        end
    endtask
    task automatic do_both(input bit noise);
        {bus.call_req, bus.ret_req} = 2'b11;
        tick();
        {bus.call_req, bus.ret_req} = 2'b00;
        expect_fault(FLT_ILL, noise);
    endtask
    initial begin
        {bus.call_req, bus.ret_req, bus.fault_clear} = 3'b000;
        bus.cur_pc = '0;
        bus.call_target = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_idle("reset");
        chk("reset push_data", bus.stk_push_data, 0);
        do_call(19'h00100, 19'h02000, 1'b0);
        do_ret(1'b0);
        chk("ret empty", bus.stk_empty, 1);
        do_ret(1'b0);
        do_both(1'b0);
        for (int i = 0; i < DEPTH; i++) do_call(19'($urandom), 19'($urandom), 1'b0);
        chk("full", bus.stk_full, 1);
        do_call(19'h00abc, 19'h00def, 1'b0);
        chk("ovf no push", sp, 0);
        repeat (DEPTH) do_ret(1'b0);
        do_call(19'h7ffff, 19'h12345, 1'b1);
        do_ret(1'b1);
        do_call(19'h00400, 19'h00500, 1'b0);
        bus.call_req = 1'b1;
        bus.cur_pc = 19'h00777;
        tick();
        bus.call_req = 1'b0;
        chk("abort push", bus.stk_push, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ref_q.delete();
        exp_pc = '0;
        check_idle("abort");
        chk("abort push_data", bus.stk_push_data, 0);
        chk("abort sp", sp, 15);
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 6) do_call(($urandom_range(0, 7) == 0) ? 19'h7ffff : 19'($urandom), 19'($urandom), 1'($urandom));
            else if (r < 9) do_ret(1'($urandom));
            else do_both(1'($urandom));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/call_return_ctrl.md
# call_return_ctrl

Call/return sequencer that drives the CPU's 16-entry, 19-bit hardware return-address stack. On CALL it pushes `cur_pc + 1` and redirects to the call target. On RET it pops the saved address and redirects to it. It sits between instruction decode and the stack, detects overflow, underflow and illegal requests, and reports them as sticky faults.

## Interface
Parameters:
- ADDR_W, 19, program-counter and stack-entry width
- DEPTH, 15, usable stack entries; the stack is empty at sp=15 and full at sp=0

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- call_req  in  1  CALL request; sampled only when busy=0
- ret_req  in  1  RET request; sampled only when busy=0
- cur_pc  in  ADDR_W  PC of the CALL instruction; sampled with call_req
- call_target  in  ADDR_W  CALL destination; sampled with call_req
- fault_clear  in  1  leaves the FAULT state
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse; next_pc is valid during it
- next_pc  out  ADDR_W  redirect address
- fault  out  1  high while in FAULT
- fault_code  out  2  0 none, 1 overflow, 2 underflow, 3 illegal
- call_depth  out  4  current nesting depth (0..DEPTH)
- stk_push  out  1  to stack push
- stk_pop  out  1  to stack pop
- stk_push_data  out  ADDR_W  to stack push_data
- stk_pop_data  in  ADDR_W  from stack pop_data; combinational top-of-stack
- stk_empty  in  1  from stack
- stk_full  in  1  from stack

## Operation
- FSM states: IDLE, CALL_PUSH, RET_POP, RESP, FAULT.
- IDLE, call_req=1, ret_req=0:
  - If stk_full: go to FAULT with code 1.
  - Otherwise: latch ret_addr = (cur_pc + 1) mod 2^19 (0x7FFFF wraps to 0x00000) and tgt = call_target, then go to CALL_PUSH.
- IDLE, ret_req=1, call_req=0:
  - If stk_empty: go to FAULT with code 2.
  - Otherwise: go to RET_POP.
- IDLE, call_req and ret_req both 1: go to FAULT with code 3. Illegal has priority over the full/empty checks.
- CALL_PUSH:
  - stk_push=1 and stk_push_data=ret_addr, for exactly one cycle.
  - call_depth increments.
  - next_pc is set to tgt.
  - Go to RESP.
- RET_POP:
  - stk_pop=1 for exactly one cycle.
  - next_pc captures stk_pop_data at the end of this cycle.
  - call_depth decrements.
  - Go to RESP.
- RESP: done=1, then go to IDLE.
- FAULT:
  - No stack traffic; fault=1; fault_code is held.
  - Stay until fault_clear=1, then go to IDLE with fault_code=0 on the next edge.
- While busy=1, requests are ignored and are not queued; the requester must re-present them.
- stk_push and stk_pop are never high together, and are never high outside CALL_PUSH or RET_POP.
- call_depth never wraps. It is bounded by the full/empty checks.

## Timing
- Reset values (all outputs): state=IDLE, busy=0, done=0, next_pc=0, fault=0, fault_code=0, call_depth=0, stk_push=0, stk_pop=0, stk_push_data=0.
- Reset applies in any state and aborts an in-flight push or pop. The stack shares the same reset, so depth stays consistent.
- Request sampled at edge N:
  - busy is high from cycle N+1.
  - Stack strobe in cycle N+1.
  - done and a valid next_pc in cycle N+2.
  - busy=0 in cycle N+3, and the next request can be sampled at edge N+3.
- Fault detected at edge N: fault=1 from cycle N+1. If fault_clear is sampled at edge M, fault=0 and busy=0 in cycle M+1.
- next_pc holds its value until the next CALL_PUSH or RET_POP.

## Structure
- Shared package `cpu19_pkg` holds ADDR_W, the FSM state typedef, and the fault-code constants (FLT_NONE, FLT_OVF, FLT_UNF, FLT_ILL).
- The block has no sub-module. It is a single FSM with registers and one adder. The stack is instantiated beside it at the CPU top level, and the two are connected port-to-port.

## Test plan
- CALL: cur_pc=0x00100, call_target=0x02000 -> stk_push for 1 cycle with data 0x00101; done with next_pc=0x02000; call_depth=1.
- CALL then RET, with the real stack attached -> RET gives done with next_pc=0x00101; call_depth=0; stk_empty=1.
- 15 nested CALLs, then a 16th -> the 16th produces fault=1, fault_code=1 and no push; after fault_clear, busy=0 in the following cycle.
- RET after reset -> fault_code=2 and no pop. call_req and ret_req together -> fault_code=3.
- CALL with cur_pc=0x7FFFF -> pushed 0x00000. A request raised while busy=1 is ignored and produces no extra done.
- Reset asserted during CALL_PUSH -> next cycle all outputs are at their reset values and stack sp=15.
